// File: rtl/fc_layer_if.sv
// Signal bundle between the pooling stage, the weight loader and the dense layer.
// master drives samples/weights/start; slave is the fc_layer side.
interface fc_layer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N_IN       = 9,
    parameter int N_OUT      = 4
);
    localparam int AW = $clog2(N_OUT * N_IN + N_OUT) + 1;
    localparam int IW = $clog2(N_OUT) + 1;

    // Streams are qualified by a single-cycle valid; there is no backpressure,
    // the producer must hold off a new map until o_done.
    logic                  i_start;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  i_w_we;
    logic [AW-1:0]         i_w_addr;
    logic [DATA_WIDTH-1:0] i_w_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic [IW-1:0]         o_idx;
    logic                  o_busy;
    logic                  o_done;
    logic [1:0]            o_state;

    modport master (
        output i_start, i_data, i_valid, i_w_we, i_w_addr, i_w_data,
        input  o_data, o_valid, o_idx, o_busy, o_done, o_state
    );

    modport slave (
        input  i_start, i_data, i_valid, i_w_we, i_w_addr, i_w_data,
        output o_data, o_valid, o_idx, o_busy, o_done, o_state
    );
endinterface

// File: rtl/fc_layer.sv
// Dense layer: N_IN Q8.8 samples into N_OUT parallel accumulators, results emitted serially.
// Optional bias registers are enabled with the FC_LAYER_BIAS_EN macro.
module fc_layer #(
    parameter int DATA_WIDTH = 16,
    parameter int N_IN       = 9,
    parameter int N_OUT      = 4,
    parameter int ACC_WIDTH  = 40
) (
    input  logic       i_clk,
    input  logic       i_rst,
    fc_layer_if.slave  bus
);
    localparam int NW  = N_OUT * N_IN;
    localparam int AW  = $clog2(NW + N_OUT) + 1;
    localparam int IW  = $clog2(N_OUT) + 1;
    localparam int WIX = $clog2(NW);
    localparam int CW  = $clog2(N_IN);
    localparam int OW  = $clog2(N_OUT);
    localparam int PW  = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_EMIT = 2'd2} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 in_cnt;
    logic [OW-1:0]                 out_cnt;
    logic signed [ACC_WIDTH-1:0]   acc      [N_OUT];
    logic signed [ACC_WIDTH-1:0]   acc_init [N_OUT];
    logic signed [PW-1:0]          prod     [N_OUT];
    logic signed [DATA_WIDTH-1:0]  w_mem    [NW];
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]         emit_data;
    logic                          w_ok, last_in, last_out, acc_clear, acc_step;

    assign w_ok     = bus.i_w_we && (state_q == S_IDLE);
    assign last_in  = (in_cnt == CW'(N_IN - 1));
    assign last_out = (out_cnt == OW'(N_OUT - 1));

    // Weight file is deliberately not reset; it survives aborted inferences.
    always_ff @(posedge i_clk) begin
        if (w_ok && (int'(bus.i_w_addr) < NW))
            w_mem[bus.i_w_addr[WIX-1:0]] <= bus.i_w_data;
    end

`ifdef FC_LAYER_BIAS_EN
    logic signed [DATA_WIDTH-1:0] bias [N_OUT];
    logic [OW-1:0]                b_idx;

    assign b_idx = OW'(bus.i_w_addr - AW'(NW));

    always_ff @(posedge i_clk) begin
        if (w_ok && (int'(bus.i_w_addr) >= NW) && (int'(bus.i_w_addr) < NW + N_OUT))
            bias[b_idx] <= bus.i_w_data;
    end

    // Q8.8 bias moved up to the Q.16 accumulator alignment.
    always_comb begin
        for (int k = 0; k < N_OUT; k++)
            acc_init[k] = {{(ACC_WIDTH-DATA_WIDTH-8){bias[k][DATA_WIDTH-1]}}, bias[k], 8'b0};
    end
`else
    always_comb begin
        for (int k = 0; k < N_OUT; k++)
            acc_init[k] = '0;
    end
`endif

    always_comb begin
        for (int k = 0; k < N_OUT; k++)
            prod[k] = w_mem[WIX'(k * N_IN) + WIX'(in_cnt)] * $signed(bus.i_data);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Restart in ACCUM wins over a coincident sample, which is dropped.
    always_comb begin
        state_d   = state_q;
        acc_clear = 1'b0;
        acc_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    acc_clear = 1'b1;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.i_start) begin
                    acc_clear = 1'b1;
                end else if (bus.i_valid) begin
                    acc_step = 1'b1;
                    if (last_in) state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (last_out) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
        end else begin
            if (acc_clear) begin
                in_cnt <= '0;
                for (int k = 0; k < N_OUT; k++) acc[k] <= acc_init[k];
            end else if (acc_step) begin
                in_cnt <= last_in ? '0 : in_cnt + 1'b1;
                if (last_in) out_cnt <= '0;
                for (int k = 0; k < N_OUT; k++)
                    acc[k] <= acc[k] + {{(ACC_WIDTH-PW){prod[k][PW-1]}}, prod[k]};
            end
            if (state_q == S_EMIT)
                out_cnt <= last_out ? '0 : out_cnt + 1'b1;
        end
    end

    // Saturate when the bits above the Q8.8 window are not pure sign copies.
    always_comb begin
        shifted = acc[out_cnt] >>> 8;
        if ((&shifted[ACC_WIDTH-1:DATA_WIDTH-1]) || ~(|shifted[ACC_WIDTH-1:DATA_WIDTH-1]))
            emit_data = shifted[DATA_WIDTH-1:0];
        else if (shifted[ACC_WIDTH-1])
            emit_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            emit_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    assign bus.o_valid = (state_q == S_EMIT);
    assign bus.o_idx   = bus.o_valid ? IW'(out_cnt) : '0;
    assign bus.o_data  = bus.o_valid ? emit_data : '0;
    assign bus.o_done  = bus.o_valid && last_out;
    assign bus.o_busy  = (state_q != S_IDLE);
    assign bus.o_state = state_q;
endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: weight load, inference, saturation, gaps, restart, async reset.
// Bias expectations follow the FC_LAYER_BIAS_EN macro.
module tb_fc_layer;
    localparam int DW    = 16;
    localparam int N_IN  = 9;
    localparam int N_OUT = 4;
    localparam int AW    = $clog2(N_OUT * N_IN + N_OUT) + 1;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    fc_layer_if #(.DATA_WIDTH(DW), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    fc_layer #(.DATA_WIDTH(DW), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_WIDTH(40)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        bus.i_start  = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_w_we   = 1'b0;
        bus.i_w_addr = '0;
        bus.i_w_data = '0;
    endtask

    task automatic write_w(input int addr, input logic [DW-1:0] val);
        @(negedge i_clk);
        idle_inputs();
        bus.i_w_we   = 1'b1;
        bus.i_w_addr = AW'(addr);
        bus.i_w_data = val;
    endtask

    // Neuron k gets weight base + k*step on every input.
    task automatic load_weights(input logic [DW-1:0] base, input logic [DW-1:0] step);
        for (int k = 0; k < N_OUT; k++)
            for (int i = 0; i < N_IN; i++)
                write_w(k * N_IN + i, base + DW'(k) * step);
    endtask

    task automatic feed(input logic [DW-1:0] din, input int gap_max, input bit w_mid, input bit restart5);
        @(negedge i_clk);
        idle_inputs();
        bus.i_start = 1'b1;
        @(negedge i_clk);
        check("busy_in_accum", 32'(bus.o_busy), 32'd1);
        check("state_accum", 32'(bus.o_state), 32'd1);
        idle_inputs();
        if (restart5) begin
            for (int i = 0; i < 5; i++) begin
                bus.i_valid = 1'b1;
                bus.i_data  = 16'h7FFF;
                @(negedge i_clk);
                idle_inputs();
            end
            bus.i_start = 1'b1;
            bus.i_valid = 1'b1;
            bus.i_data  = 16'h7FFF;
            @(negedge i_clk);
            idle_inputs();
        end
        for (int i = 0; i < N_IN; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                @(negedge i_clk);
                idle_inputs();
            end
            if (w_mid && i == 4) begin
                bus.i_w_we   = 1'b1;
                bus.i_w_addr = '0;
                bus.i_w_data = 16'h7FFF;
                @(negedge i_clk);
                idle_inputs();
            end
            bus.i_valid = 1'b1;
            bus.i_data  = din;
            if (i < N_IN - 1) begin
                @(negedge i_clk);
                idle_inputs();
            end
        end
    endtask

    // Results must start on the negedge right after the last sample was driven.
    task automatic collect(input bit start_in_emit);
        for (int j = 0; j < N_OUT; j++) begin
            logic [DW-1:0] e;
            @(negedge i_clk);
            e = exp_q.pop_front();
            check("o_valid", 32'(bus.o_valid), 32'd1);
            check("o_idx", 32'(bus.o_idx), 32'(j));
            check("o_data", 32'(bus.o_data), 32'(e));
            check("o_done", 32'(bus.o_done), (j == N_OUT - 1) ? 32'd1 : 32'd0);
            idle_inputs();
            if (start_in_emit && j == 1) begin
                bus.i_start = 1'b1;
                bus.i_valid = 1'b1;
                bus.i_data  = 16'h7FFF;
            end
        end
        @(negedge i_clk);
        check("busy_after_done", 32'(bus.o_busy), 32'd0);
        check("valid_after_done", 32'(bus.o_valid), 32'd0);
        idle_inputs();
    endtask

    task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    initial begin
        idle_inputs();
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_data", 32'(bus.o_data), 32'd0);
        check("rst_idx", 32'(bus.o_idx), 32'd0);
        check("rst_state", 32'(bus.o_state), 32'd0);
        i_rst = 1'b1;

        // A sample in IDLE must not wake the layer.
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_data  = 16'h0100;
        @(negedge i_clk);
        idle_inputs();
        check("idle_valid_ignored", 32'(bus.o_busy), 32'd0);

        // Unity weights and inputs; start during EMIT is ignored.
        load_weights(16'h0100, 16'h0000);
        push4(16'h0900, 16'h0900, 16'h0900, 16'h0900);
        feed(16'h0100, 0, 1'b0, 1'b0);
        collect(1'b1);

        // Per-neuron scaled weights.
        load_weights(16'h0080, 16'h0080);
        push4(16'h0900, 16'h1200, 16'h1B00, 16'h2400);
        feed(16'h0200, 0, 1'b0, 1'b0);
        collect(1'b0);

        // Random valid gaps plus a weight write mid-accumulation.
        push4(16'h0900, 16'h1200, 16'h1B00, 16'h2400);
        feed(16'h0200, 3, 1'b1, 1'b0);
        collect(1'b0);

        // Restart after 5 samples; the restart-cycle sample is dropped.
        push4(16'h0900, 16'h1200, 16'h1B00, 16'h2400);
        feed(16'h0200, 0, 1'b0, 1'b1);
        collect(1'b0);

        // Positive and negative saturation.
        load_weights(16'h7FFF, 16'h0000);
        push4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        feed(16'h7FFF, 0, 1'b0, 1'b0);
        collect(1'b0);

        load_weights(16'hFF00, 16'h0000);
        push4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        feed(16'h7F00, 0, 1'b0, 1'b0);
        collect(1'b0);

        // Asynchronous reset in the middle of EMIT.
        feed(16'h7F00, 0, 1'b0, 1'b0);
        @(negedge i_clk);
        idle_inputs();
        check("pre_reset_valid", 32'(bus.o_valid), 32'd1);
        #2 i_rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.o_valid), 32'd0);
        check("async_rst_done", 32'(bus.o_done), 32'd0);
        check("async_rst_busy", 32'(bus.o_busy), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // Weights survive the reset.
        push4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        feed(16'h7F00, 0, 1'b0, 1'b0);
        collect(1'b0);

        // Bias region: -1.0 per neuron when enabled, ignored otherwise.
        load_weights(16'h0100, 16'h0000);
        for (int k = 0; k < N_OUT; k++) write_w(N_OUT * N_IN + k, 16'hFF00);
`ifdef FC_LAYER_BIAS_EN
        push4(16'h0800, 16'h0800, 16'h0800, 16'h0800);
`else
        push4(16'h0900, 16'h0900, 16'h0900, 16'h0900);
`endif
        feed(16'h0100, 0, 1'b0, 1'b0);
        collect(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
